// File: rtl/ch_est_ctrl_unit.sv
// NB-IoT channel-estimation control: pilot read sequencing for both slots
// and the v_shift-dependent interpolation select/enable program.
module ch_est_ctrl_unit #(
  parameter int NRS_ADDR = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                demap_ready,
  input  logic                NRS_gen_ready,
  input  logic [2:0]          v_shift,
  output logic [3:0]          col,
  output logic [1:0]          nrs_index_addr,
  output logic                demap_read,
  output logic [NRS_ADDR-1:0] rd_addr_nrs,
  output logic                valid_eqlz,
  output logic [1:0]          addr_mem,
  output logic                mult_mem_en,
  output logic                avg_mem_en,
  output logic                en_reg_E,
  output logic                en_reg_2E,
  output logic                en_reg_5E,
  output logic [2:0]          s1a,
  output logic [2:0]          s1b,
  output logic [2:0]          s2a,
  output logic [2:0]          s2b,
  output logic [1:0]          s_h1,
  output logic [1:0]          s_h2,
  output logic                s_est
);

  typedef enum logic [1:0] {IDLE, MULT_STORE, MULT_ADD} state_t;
  typedef enum logic [1:0] {CLS_A, CLS_B, CLS_C} cls_t;

  typedef struct packed {
    logic [2:0] s1a;
    logic [2:0] s1b;
    logic [2:0] s2a;
    logic [2:0] s2b;
    logic [1:0] s_h1;
    logic [1:0] s_h2;
    logic       valid;
    logic       e;
    logic       e2;
    logic       e5;
  } row_t;

  localparam row_t IDLE_ROW = '{3'd7, 3'd7, 3'd7, 3'd7,
                                2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0};

  function automatic cls_t cls_of(input logic [2:0] v);
    case (v)
      3'd0, 3'd3, 3'd6: return CLS_A;
      3'd1, 3'd4, 3'd7: return CLS_B;
      default:          return CLS_C;
    endcase
  endfunction

  function automatic row_t mk(
    input int a, input int b, input int c, input int d,
    input int h1, input int h2,
    input int v, input int e, input int e2, input int e5
  );
    row_t r;
    r.s1a   = 3'(a);
    r.s1b   = 3'(b);
    r.s2a   = 3'(c);
    r.s2b   = 3'(d);
    r.s_h1  = 2'(h1);
    r.s_h2  = 2'(h2);
    r.valid = 1'(v);
    r.e     = 1'(e);
    r.e2    = 1'(e2);
    r.e5    = 1'(e5);
    return r;
  endfunction

  function automatic row_t prog_row(input cls_t c, input logic [3:0] s);
    case ({c, s})
      {CLS_A, 4'd0}: return mk(0, 0, 7, 7, 0, 0, 0, 0, 0, 0);
      {CLS_A, 4'd1}: return mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      {CLS_A, 4'd2}: return mk(1, 0, 1, 1, 1, 1, 1, 0, 1, 0);
      {CLS_A, 4'd3}: return mk(3, 1, 3, 0, 3, 0, 1, 0, 0, 0);
      {CLS_A, 4'd4}: return mk(3, 1, 3, 3, 2, 0, 1, 0, 0, 0);
      {CLS_A, 4'd5}: return mk(3, 3, 2, 3, 3, 3, 1, 0, 0, 0);
      {CLS_A, 4'd6}: return mk(2, 2, 2, 2, 1, 2, 1, 0, 0, 1);
      {CLS_B, 4'd0}: return mk(7, 7, 6, 6, 0, 0, 0, 0, 0, 0);
      {CLS_B, 4'd1}: return mk(7, 7, 4, 4, 1, 1, 0, 0, 1, 0);
      {CLS_B, 4'd2}: return mk(6, 6, 0, 0, 1, 2, 1, 0, 0, 0);
      {CLS_B, 4'd3}: return mk(3, 1, 0, 0, 0, 2, 1, 0, 0, 0);
      {CLS_B, 4'd4}: return mk(0, 0, 3, 0, 1, 3, 1, 0, 0, 0);
      {CLS_B, 4'd5}: return mk(3, 3, 3, 3, 3, 2, 1, 1, 0, 0);
      {CLS_B, 4'd6}: return mk(7, 7, 2, 2, 2, 0, 1, 0, 0, 0);
      {CLS_C, 4'd0}: return mk(7, 7, 1, 4, 0, 0, 0, 0, 0, 0);
      {CLS_C, 4'd1}: return mk(4, 0, 6, 6, 0, 0, 0, 0, 0, 1);
      {CLS_C, 4'd2}: return mk(5, 4, 4, 4, 3, 0, 0, 1, 1, 0);
      {CLS_C, 4'd3}: return mk(5, 4, 0, 0, 0, 0, 1, 0, 0, 0);
      {CLS_C, 4'd4}: return mk(6, 6, 0, 0, 3, 1, 1, 0, 0, 0);
      {CLS_C, 4'd5}: return mk(3, 1, 3, 0, 3, 0, 1, 0, 0, 0);
      {CLS_C, 4'd6}: return mk(3, 1, 3, 3, 2, 2, 1, 0, 0, 0);
      {CLS_C, 4'd7}: return mk(3, 3, 7, 7, 1, 3, 1, 0, 0, 0);
      default:       return IDLE_ROW;
    endcase
  endfunction

  state_t              state, state_nx;
  logic                slot2;
  logic [1:0]          p;
  logic [NRS_ADDR-1:0] rd_cnt;
  cls_t                cls, prog_cls;
  logic [1:0]          dly;
  logic                prog_act;
  logic [3:0]          step;
  logic                run, prog_go;
  logic [3:0]          last;
  row_t                row;

  assign run     = (state != IDLE);
  assign prog_go = (state == MULT_ADD) && (p == 2'd0);
  assign last    = (prog_cls == CLS_C) ? 4'd8 : 4'd7;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (demap_ready && NRS_gen_ready)
          state_nx = slot2 ? MULT_ADD : MULT_STORE;
      end
      MULT_STORE, MULT_ADD: begin
        if (p == 2'd3) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot2       <= 1'b0;
      p           <= 2'd0;
      rd_cnt      <= '0;
      mult_mem_en <= 1'b0;
      avg_mem_en  <= 1'b0;
      cls         <= CLS_A;
      prog_cls    <= CLS_A;
      dly         <= 2'd0;
      prog_act    <= 1'b0;
      step        <= 4'd0;
    end else begin
      mult_mem_en <= (state == MULT_STORE);
      avg_mem_en  <= (state == MULT_ADD);
      if (run) begin
        p      <= p + 2'd1;
        rd_cnt <= rd_cnt + NRS_ADDR'(2);
        if (p == 2'd3) slot2 <= ~slot2;
      end
      if (state == IDLE && state_nx == MULT_STORE)
        cls <= cls_of(v_shift);
      // class B waits one extra cycle before its first step
      if (prog_go) begin
        dly      <= (cls == CLS_B) ? 2'd2 : 2'd1;
        prog_cls <= cls;
      end else if (dly != 2'd0) begin
        dly <= dly - 2'd1;
      end
      if (dly == 2'd1) begin
        prog_act <= 1'b1;
        step     <= 4'd0;
      end else if (prog_act) begin
        if (step == last) begin
          prog_act <= 1'b0;
          step     <= 4'd0;
        end else begin
          step <= step + 4'd1;
        end
      end
    end
  end

  always_comb begin
    row = IDLE_ROW;
    if (prog_act) row = prog_row(prog_cls, step);
  end

  assign demap_read     = run;
  assign nrs_index_addr = p;
  assign addr_mem       = p;
  assign rd_addr_nrs    = rd_cnt;
  assign col            = run ? ((slot2 ? 4'd12 : 4'd5) + {3'b000, p[1]})
                              : 4'd0;
  assign s_est          = (v_shift == 3'd1) || (v_shift == 3'd4);
  assign s1a            = row.s1a;
  assign s1b            = row.s1b;
  assign s2a            = row.s2a;
  assign s2b            = row.s2b;
  assign s_h1           = row.s_h1;
  assign s_h2           = row.s_h2;
  assign valid_eqlz     = row.valid;
  assign en_reg_E       = row.e;
  assign en_reg_2E      = row.e2;
  assign en_reg_5E      = row.e5;

endmodule

// File: tb/tb_ch_est_ctrl_unit.sv
// Directed bench for ch_est_ctrl_unit: idle hold, slot runs,
// per-class interpolation programs, back-to-back operation and reset abort.
module tb_ch_est_ctrl_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       demap_ready, NRS_gen_ready;
  logic [2:0] v_shift;
  logic [3:0] col;
  logic [1:0] nrs_index_addr, addr_mem;
  logic       demap_read, valid_eqlz, mult_mem_en, avg_mem_en;
  logic [3:0] rd_addr_nrs;
  logic       en_reg_E, en_reg_2E, en_reg_5E, s_est;
  logic [2:0] s1a, s1b, s2a, s2b;
  logic [1:0] s_h1, s_h2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ch_est_ctrl_unit #(.NRS_ADDR(4)) dut (
    .clk(clk), .rst(rst),
    .demap_ready(demap_ready), .NRS_gen_ready(NRS_gen_ready),
    .v_shift(v_shift), .col(col), .nrs_index_addr(nrs_index_addr),
    .demap_read(demap_read), .rd_addr_nrs(rd_addr_nrs),
    .valid_eqlz(valid_eqlz), .addr_mem(addr_mem),
    .mult_mem_en(mult_mem_en), .avg_mem_en(avg_mem_en),
    .en_reg_E(en_reg_E), .en_reg_2E(en_reg_2E), .en_reg_5E(en_reg_5E),
    .s1a(s1a), .s1b(s1b), .s2a(s2a), .s2b(s2b),
    .s_h1(s_h1), .s_h2(s_h2), .s_est(s_est)
  );

  logic [34:0] outs;
  logic [14:0] run_v;
  logic [19:0] pv;

  assign outs  = {col, nrs_index_addr, demap_read, rd_addr_nrs, valid_eqlz,
                  addr_mem, mult_mem_en, avg_mem_en,
                  en_reg_E, en_reg_2E, en_reg_5E,
                  s1a, s1b, s2a, s2b, s_h1, s_h2};
  assign run_v = {col, nrs_index_addr, addr_mem, demap_read, rd_addr_nrs,
                  mult_mem_en, avg_mem_en};
  assign pv    = {s1a, s1b, s2a, s2b, s_h1, s_h2,
                  valid_eqlz, en_reg_E, en_reg_2E, en_reg_5E};

  localparam logic [34:0] RESET_VEC = {4'd0, 2'd0, 1'b0, 4'd0, 1'b0, 2'd0,
                                       1'b0, 1'b0, 3'b000, 12'hFFF, 4'h0};
  localparam logic [19:0] IDLE_PV = {12'hFFF, 4'h0, 4'h0};

  // step tables per class (A, B, C); A/B step 8 is padding
  int t_s1a [3][9] = '{'{0,1,1,3,3,3,2,7,7}, '{7,7,6,3,0,3,7,7,7},
                       '{7,4,5,5,6,3,3,3,7}};
  int t_s1b [3][9] = '{'{0,0,0,1,1,3,2,7,7}, '{7,7,6,1,0,3,7,7,7},
                       '{7,0,4,4,6,1,1,3,7}};
  int t_s2a [3][9] = '{'{7,0,1,3,3,2,2,7,7}, '{6,4,0,0,3,3,2,7,7},
                       '{1,6,4,0,0,3,3,7,7}};
  int t_s2b [3][9] = '{'{7,0,1,0,3,3,2,7,7}, '{6,4,0,0,0,3,2,7,7},
                       '{4,6,4,0,0,0,3,7,7}};
  int t_sh1 [3][9] = '{'{0,0,1,3,2,3,1,0,0}, '{0,1,1,0,1,3,2,0,0},
                       '{0,0,3,0,3,3,2,1,0}};
  int t_sh2 [3][9] = '{'{0,0,1,0,0,3,2,0,0}, '{0,1,2,2,3,2,0,0,0},
                       '{0,0,0,0,1,0,2,3,0}};
  int e_step  [3] = '{1, 5, 2};
  int e2_step [3] = '{2, 1, 2};
  int e5_step [3] = '{6, -1, 1};

  function automatic logic [19:0] exp_pv(input int c, input int s);
    int n, vlo;
    n   = (c == 2) ? 9 : 8;
    vlo = (c == 2) ? 3 : 2;
    if (s < 0 || s >= n) return IDLE_PV;
    return {3'(t_s1a[c][s]), 3'(t_s1b[c][s]), 3'(t_s2a[c][s]),
            3'(t_s2b[c][s]), 2'(t_sh1[c][s]), 2'(t_sh2[c][s]),
            1'(s >= vlo && s <= vlo + 4), 1'(s == e_step[c]),
            1'(s == e2_step[c]), 1'(s == e5_step[c])};
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    demap_ready = 1'b0;
    NRS_gen_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    v_shift = 3'd0;
    rst = 1'b1;
    demap_ready = 1'b0;
    NRS_gen_ready = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if (outs !== RESET_VEC) begin
      n_fail++;
      $display("FAIL reset_held: got %h want %h", outs, RESET_VEC);
    end
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (outs !== RESET_VEC || s_est !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_released: got %h/%b want %h/0",
               outs, s_est, RESET_VEC);
    end
  endtask

  task automatic test_idle_hold();
    logic [1:0] pat [3] = '{2'b00, 2'b01, 2'b10};
    logic [34:0] bad;
    bit ok;
    for (int v = 0; v < 6; v++) begin
      for (int k = 0; k < 3; k++) begin
        v_shift = 3'(v);
        {demap_ready, NRS_gen_ready} = pat[k];
        ok = 1'b1;
        bad = '0;
        for (int c = 0; c < 100; c++) begin
          @(negedge clk);
          if (ok && outs !== RESET_VEC) begin
            ok = 1'b0;
            bad = outs;
          end
        end
        n_tests++;
        if (!ok) begin
          n_fail++;
          $display("FAIL idle_hold v=%0d rdy=%b: got %h want %h",
                   v, pat[k], bad, RESET_VEC);
        end
      end
      n_tests++;
      if (s_est !== (v == 1 || v == 4)) begin
        n_fail++;
        $display("FAIL s_est v=%0d: got %b want %b", v, s_est, v == 1 || v == 4);
      end
    end
    demap_ready = 1'b0;
    NRS_gen_ready = 1'b0;
  endtask

  task automatic slot_run(input bit second);
    logic [14:0] exp;
    @(negedge clk);
    demap_ready = 1'b1;
    NRS_gen_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      demap_ready = 1'b0;
      NRS_gen_ready = 1'b0;
      exp = {4'((second ? 12 : 5) + i / 2), 2'(i), 2'(i), 1'b1,
             4'((second ? 8 : 0) + 2 * i),
             1'(!second && i > 0), 1'(second && i > 0)};
      n_tests++;
      if (run_v !== exp) begin
        n_fail++;
        $display("FAIL slot%0d_p%0d: got %h want %h",
                 second ? 2 : 1, i, run_v, exp);
      end
    end
    @(negedge clk);
    n_tests++;
    if ({demap_read, mult_mem_en, avg_mem_en} !== {1'b0, !second, second}) begin
      n_fail++;
      $display("FAIL slot%0d_after: got %b want %b", second ? 2 : 1,
               {demap_read, mult_mem_en, avg_mem_en}, {1'b0, !second, second});
    end
  endtask

  task automatic test_slots();
    v_shift = 3'd0;
    slot_run(1'b0);
    repeat (9) @(negedge clk);
    slot_run(1'b1);
    repeat (14) @(negedge clk);
    n_tests++;
    if (outs !== RESET_VEC) begin
      n_fail++;
      $display("FAIL slots_settle: got %h want %h", outs, RESET_VEC);
    end
  endtask

  task automatic run_pair(input int v);
    int c, off;
    logic [19:0] exp;
    c   = v % 3;
    off = (c == 1) ? 3 : 2;
    @(negedge clk);
    v_shift = 3'(v);
    demap_ready = 1'b1;
    NRS_gen_ready = 1'b1;
    #1;
    n_tests++;
    if (s_est !== (v == 1 || v == 4)) begin
      n_fail++;
      $display("FAIL pair_s_est v=%0d: got %b", v, s_est);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_tests++;
      if ({demap_read, pv} !== {1'b1, IDLE_PV}) begin
        n_fail++;
        $display("FAIL store_idle_sel v=%0d p=%0d: got %b/%h want 1/%h",
                 v, i, demap_read, pv, IDLE_PV);
      end
    end
    repeat (2) @(negedge clk);
    NRS_gen_ready = 1'b0;
    demap_ready = 1'b0;
    for (int k = 0; k < 14; k++) begin
      if (k > 0) @(negedge clk);
      exp = exp_pv(c, k - off);
      n_tests++;
      if (pv !== exp) begin
        n_fail++;
        $display("FAIL prog v=%0d T+%0d: got %h want %h", v, k, pv, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int v = 0; v < 8; v++) run_pair(v);
  endtask

  task automatic test_reset_mid();
    logic [19:0] exp;
    @(negedge clk);
    v_shift = 3'd2;
    demap_ready = 1'b1;
    NRS_gen_ready = 1'b1;
    repeat (6) @(negedge clk);
    demap_ready = 1'b0;
    NRS_gen_ready = 1'b0;
    repeat (4) @(negedge clk);
    exp = exp_pv(2, 2);
    n_tests++;
    if (pv !== exp) begin
      n_fail++;
      $display("FAIL mid_prog_pre: got %h want %h", pv, exp);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_tests++;
    if (outs !== RESET_VEC) begin
      n_fail++;
      $display("FAIL rst_mid_prog: got %h want %h", outs, RESET_VEC);
    end
    demap_ready = 1'b1;
    NRS_gen_ready = 1'b1;
    repeat (3) @(negedge clk);
    demap_ready = 1'b0;
    NRS_gen_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_tests++;
    if (outs !== RESET_VEC) begin
      n_fail++;
      $display("FAIL rst_mid_run: got %h want %h", outs, RESET_VEC);
    end
    @(negedge clk);
    demap_ready = 1'b1;
    NRS_gen_ready = 1'b1;
    @(negedge clk);
    demap_ready = 1'b0;
    NRS_gen_ready = 1'b0;
    n_tests++;
    if (run_v !== {4'd5, 2'd0, 2'd0, 1'b1, 4'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL restart_after_rst: got %h want %h", run_v,
               {4'd5, 2'd0, 2'd0, 1'b1, 4'd0, 1'b0, 1'b0});
    end
  endtask

  initial begin
    test_reset();
    test_idle_hold();
    test_slots();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ch_est_ctrl_unit.md
Name: ch_est_ctrl_unit

Overview:
Control unit of the NB-IoT channel-estimation block. It sequences the reading of demapped NRS pilots and locally generated NRS symbols, and drives the multiplier/averager memory writes for the two slots of a subframe. It then runs a v_shift-dependent select/enable program that steers the interpolation adders and output muxes and flags valid estimates to the equalizer.

Parameters:
NRS_ADDR, 4, width of rd_addr_nrs (read address into the NRS generator memory)

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  synchronous, active-high reset
demap_ready  in  1  demapper has pilots available
NRS_gen_ready  in  1  NRS generator has symbols available
v_shift  in  3  cell frequency shift, 0..5
col  out  4  OFDM symbol index of the current pilot
nrs_index_addr  out  2  index of the pilot within the run, 0..3
demap_read  out  1  pilot read strobe to the demapper
rd_addr_nrs  out  NRS_ADDR  NRS memory read address
valid_eqlz  out  1  interpolated estimate valid to the equalizer
addr_mem  out  2  internal product/average memory address
mult_mem_en  out  1  slot-1 product memory write enable
avg_mem_en  out  1  slot-2 average memory write enable
en_reg_E, en_reg_2E, en_reg_5E  out  1 each  load enables of the interpolation step registers
s1a, s1b, s2a, s2b  out  3 each  interpolation adder mux selects
s_h1, s_h2  out  2 each  output mux selects
s_est  out  1  estimate mux select

Behaviour:
- Reset (rst=1 at a rising edge) puts the FSM in IDLE with slot=1.
- Reset values: all counters 0. col, nrs_index_addr, addr_mem and rd_addr_nrs are 0. demap_read, valid_eqlz, the mem enables and all en_reg outputs are 0. s1a/s1b/s2a/s2b are 3'b111. s_h1/s_h2 are 2'b00.
- s_est = 1 iff v_shift is 1 or 4. It is decoded combinationally.
- The class is v_shift mod 3: A = 0/3, B = 1/4, C = 2/5. v_shift 6 maps to A and 7 maps to B.
- FSM states: IDLE, MULT_STORE, MULT_ADD.
- IDLE to MULT_STORE (slot 1) or to MULT_ADD (slot 2) only when demap_ready and NRS_gen_ready are both 1. Any other combination keeps the FSM in IDLE indefinitely.
- Each run lasts 4 cycles with pilot index p = 0..3. During the run:
  - demap_read = 1.
  - nrs_index_addr = addr_mem = p.
  - col = 5,5,6,6 in slot 1 and 12,12,13,13 in slot 2.
  - rd_addr_nrs = 0 at the first slot-1 pilot and increments by 2 per pilot, modulo 2^NRS_ADDR. Slot 1 gives 0,2,4,6 and slot 2 gives 8,10,12,14. The counter holds between runs.
- The write enable is the demap_read of slot 1 (mult_mem_en) or slot 2 (avg_mem_en) delayed by one cycle. It is therefore 0 at p=0, high at p=1..3, and high in the first cycle after the run.
- After a run the FSM returns to IDLE and toggles slot; demap_read drops to 0. The wait in IDLE before slot 2 is unbounded.
- Interpolation program:
  - Let T be the first MULT_ADD cycle. The program starts at T+2 for classes A and C, and at T+3 for class B.
  - It runs 8 steps for A and B, and 9 steps for C. It runs on its own counter, independent of the FSM, which returns to IDLE/slot 1 and may restart.
  - v_shift is latched when the slot-1 run starts.
  - Per-step values, steps 0.. in order (decimal):
    A s1a 0,1,1,3,3,3,2,7; s1b 0,0,0,1,1,3,2,7; s2a 7,0,1,3,3,2,2,7; s2b 7,0,1,0,3,3,2,7; s_h1 0,0,1,3,2,3,1,0; s_h2 0,0,1,0,0,3,2,0
    B s1a 7,7,6,3,0,3,7,7; s1b 7,7,6,1,0,3,7,7; s2a 6,4,0,0,3,3,2,7; s2b 6,4,0,0,0,3,2,7; s_h1 0,1,1,0,1,3,2,0; s_h2 0,1,2,2,3,2,0,0
    C s1a 7,4,5,5,6,3,3,3,7; s1b 7,0,4,4,6,1,1,3,7; s2a 1,6,4,0,0,3,3,7,7; s2b 4,6,4,0,0,0,3,7,7; s_h1 0,0,3,0,3,3,2,1,0; s_h2 0,0,0,0,1,0,2,3,0
  - valid_eqlz is 1 on steps 2..6 (A, B) and 3..7 (C), and 0 elsewhere.
  - Single-cycle load-enable pulses:
    A: en_reg_E at step 1, en_reg_2E at step 2, en_reg_5E at step 6.
    B: en_reg_2E at step 1, en_reg_E at step 5, en_reg_5E never.
    C: en_reg_5E at step 1, en_reg_E and en_reg_2E both at step 2.
  - Outside the program, selects are 7, s_h are 0, and valid and en_reg are 0.
- Reset mid-operation aborts any run or program immediately and restores all reset values.

Test Plan:
- Reset, then hold each {demap_ready,NRS_gen_ready} ∈ {00,01,10} for 100 cycles per v_shift 0..5 -> all outputs stay at reset values.
- Slot 1 (ready pulse) -> col 5,5,6,6; nrs_index_addr/addr_mem 0..3; rd_addr_nrs 0,2,4,6; mult_mem_en 0,1,1,1; avg_mem_en 0.
- Slot 2 ready 10 cycles later -> col 12,12,13,13; rd_addr_nrs 8,10,12,14; avg_mem_en 0,1,1,1; mult_mem_en 0.
- v_shift=0, both ready held 6 cycles then NRS_gen_ready dropped -> class A program from T+2; valid on steps 2..6; en_reg pulses as specified.
- v_shift=1/4 -> class B program from T+3, s_est=1; v_shift=2/5 -> 9-step class C program.
- Back-to-back v_shift 0..5 without reset -> selects 7 and s_h 0 during each new MULT_STORE; rst asserted mid-program -> reset values on the next cycle.
